// File: rtl/pkt_serializer.sv
// Buffers {addr, data} packets in a FIFO and emits each as a 6-bit MSB-first serial frame.
// Define PKT_SERIALIZER_FLUSH_EN to add a synchronous FIFO flush input.
module pkt_serializer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
`ifdef PKT_SERIALIZER_FLUSH_EN
  input  logic                          flush,
`endif
  input  logic                          pkt_valid,
  input  logic [1:0]                    pkt_addr,
  input  logic [3:0]                    pkt_data,
  output logic                          pkt_ready,
  output logic                          out,
  output logic                          rx_ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e            state_q, state_d;
  logic [5:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   count_q;
  logic [5:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]   gap_cnt_q, gap_cnt_d;
  logic              out_q, out_d;
  logic              rx_ready_q, rx_ready_d;
  logic              flush_req;
  logic              push, pop;

`ifdef PKT_SERIALIZER_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign pkt_ready  = (count_q != CntW'(FIFO_DEPTH)) && !flush_req;
  assign push       = pkt_valid && pkt_ready;
  assign fifo_count = count_q;
  assign out        = out_q;
  assign rx_ready   = rx_ready_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {pkt_addr, pkt_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_req) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!push && pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  // Output bits are registered, so rx_ready trails the SHIFT state by one cycle.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    out_d      = 1'b0;
    rx_ready_d = 1'b0;
    pop        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0 && !flush_req) begin
          pop       = 1'b1;
          shift_d   = mem_q[rd_ptr_q];
          bit_cnt_d = 3'd6;
          state_d   = StShift;
        end
      end
      StShift: begin
        out_d      = shift_q[5];
        rx_ready_d = 1'b1;
        shift_d    = {shift_q[4:0], 1'b0};
        bit_cnt_d  = bit_cnt_q - 3'd1;
        if (bit_cnt_q == 3'd1) begin
          gap_cnt_d = GapW'(GAP_CYCLES - 1);
          state_d   = StGap;
        end
      end
      StGap: begin
        if (gap_cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q - GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      out_q      <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      out_q      <= out_d;
      rx_ready_q <= rx_ready_d;
    end
  end

endmodule
